// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM
// encodings, divide special-case results and small sign helpers.
package hilo_pkg;

  localparam logic [2:0] MD_OP_MULT  = 3'd0;
  localparam logic [2:0] MD_OP_MULTU = 3'd1;
  localparam logic [2:0] MD_OP_DIV   = 3'd2;
  localparam logic [2:0] MD_OP_DIVU  = 3'd3;
  localparam logic [2:0] MD_OP_MADD  = 3'd4;
  localparam logic [2:0] MD_OP_MADDU = 3'd5;
  localparam logic [2:0] MD_OP_MSUB  = 3'd6;
  localparam logic [2:0] MD_OP_MSUBU = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  localparam logic [31:0] DIV0_QUO = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_QUO  = 32'h8000_0000;
  localparam logic [31:0] OVF_REM  = 32'h0000_0000;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;

  function automatic logic [31:0] abs32(input logic signed [31:0] v);
    return v[31] ? -v : v;
  endfunction

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_div.sv
// 32-iteration restoring divider working on magnitudes; sign fix-up and the
// divide-by-zero / INT_MIN / -1 special cases are applied on the outputs.
module hilo_div
  import hilo_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cancel,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        last,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int CNT_W = $clog2(DIV_CYCLES) + 1;

  logic             busy_r;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      quo_p0, rem_p0, dvs_p0, dvd_p0;
  logic             neg_q_p0, neg_r_p0, dvz_p0, ovf_p0;
  logic [32:0]      shifted;
  logic             fits;
  logic [31:0]      step_quo, step_rem;
  logic             load;

  assign load = start && !busy_r;
  assign last = busy_r && (cnt == CNT_W'(DIV_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cancel) begin
        busy_r <= 1'b0;
        cnt    <= '0;
      end else if (load) begin
        busy_r <= 1'b1;
        cnt    <= '0;
      end else if (busy_r) begin
        if (last) begin
          busy_r <= 1'b0;
          cnt    <= '0;
          done   <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // One restoring step: shift the next dividend bit in, subtract if it fits.
  always_comb begin
    shifted  = {rem_p0, quo_p0[31]};
    fits     = shifted >= {1'b0, dvs_p0};
    step_rem = fits ? 32'(shifted - {1'b0, dvs_p0}) : shifted[31:0];
    step_quo = {quo_p0[30:0], fits};
  end

  always_ff @(posedge clk) begin
    if (load) begin
      quo_p0   <= is_signed ? abs32(dividend) : dividend;
      dvs_p0   <= is_signed ? abs32(divisor) : divisor;
      rem_p0   <= '0;
      dvd_p0   <= dividend;
      neg_q_p0 <= is_signed && (dividend[31] ^ divisor[31]);
      neg_r_p0 <= is_signed && dividend[31];
      dvz_p0   <= (divisor == 32'd0);
      ovf_p0   <= is_signed && (dividend == INT_MIN) && (divisor == 32'hFFFF_FFFF);
    end else if (busy_r) begin
      quo_p0 <= step_quo;
      rem_p0 <= step_rem;
    end
  end

  always_comb begin
    if (dvz_p0) begin
      quotient  = DIV0_QUO;
      remainder = dvd_p0;
    end else if (ovf_p0) begin
      quotient  = OVF_QUO;
      remainder = OVF_REM;
    end else begin
      quotient  = neg_if(quo_p0, neg_q_p0);
      remainder = neg_if(rem_p0, neg_r_p0);
    end
  end

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register owner with multi-cycle multiply/divide and read bypass.
// Build option HILO_MADD_EN enables MADD/MADDU/MSUB/MSUBU on ops 4-7.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hilo_write_en,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] md_operand_1,
  input  logic [31:0] md_operand_2,
  input  logic        flush,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  md_state_e state, state_nxt;
  logic [2:0]  mul_cnt;
  logic [31:0] hi_r, lo_r;
  logic [2:0]  op_p0;
  logic [31:0] op1_p0, op2_p0;

  logic        op_is_mul, op_is_div, accept, start_mul, start_div;
  logic        commit, res_is_div, mul_signed;
  logic signed [32:0] mul_a, mul_b;
  logic [63:0] product, mul_res, md_result;
  logic        div_last, div_done;
  logic [31:0] div_quo, div_rem;

  always_comb begin
    op_is_div = (md_op == MD_OP_DIV) || (md_op == MD_OP_DIVU);
`ifdef HILO_MADD_EN
    op_is_mul = (md_op == MD_OP_MULT) || (md_op == MD_OP_MULTU) || md_op[2];
`else
    op_is_mul = (md_op == MD_OP_MULT) || (md_op == MD_OP_MULTU);
`endif
  end

  assign accept    = md_start && (state == ST_IDLE) && !flush;
  assign start_mul = accept && op_is_mul;
  assign start_div = accept && op_is_div;

  always_comb begin
    state_nxt = state;
    md_busy   = (state != ST_IDLE);
    md_done   = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_mul) begin
          if (MUL_CYCLES == 1) state_nxt = ST_DONE;
          else                 state_nxt = ST_MUL;
        end else if (start_div) begin
          state_nxt = ST_DIV;
        end
      end
      ST_MUL:  if (mul_cnt == 3'(MUL_CYCLES - 1)) state_nxt = ST_DONE;
      ST_DIV:  if (div_last) state_nxt = ST_DONE;
      ST_DONE: begin
        state_nxt = ST_IDLE;
        commit    = !flush && (!res_is_div || div_done);
        md_done   = commit;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      mul_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == ST_MUL) mul_cnt <= (state == ST_MUL) ? mul_cnt + 3'd1 : 3'd1;
      else                     mul_cnt <= '0;
    end
  end

  // Stage p0: operands latched in the start cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0  <= md_op;
      op1_p0 <= md_operand_1;
      op2_p0 <= md_operand_2;
    end
  end

  assign res_is_div = (op_p0 == MD_OP_DIV) || (op_p0 == MD_OP_DIVU);

  always_comb begin
`ifdef HILO_MADD_EN
    mul_signed = (op_p0 == MD_OP_MULT) || (op_p0 == MD_OP_MADD) || (op_p0 == MD_OP_MSUB);
`else
    mul_signed = (op_p0 == MD_OP_MULT);
`endif
    mul_a   = {mul_signed & op1_p0[31], op1_p0};
    mul_b   = {mul_signed & op2_p0[31], op2_p0};
    product = 64'(mul_a * mul_b);
  end

`ifdef HILO_MADD_EN
  logic [63:0] hilo_base;

  // Accumulator is the bypassed HI/LO so a same-cycle MTHI/MTLO is folded in.
  always_comb begin
    hilo_base = hilo_write_en ? {hi_in, lo_in} : {hi_r, lo_r};
    case (op_p0)
      MD_OP_MADD, MD_OP_MADDU: mul_res = hilo_base + product;
      MD_OP_MSUB, MD_OP_MSUBU: mul_res = hilo_base - product;
      default:                 mul_res = product;
    endcase
  end
`else
  assign mul_res = product;
`endif

  assign md_result = res_is_div ? {div_rem, div_quo} : mul_res;

  hilo_div #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (start_div),
    .cancel    (flush),
    .is_signed (md_op == MD_OP_DIV),
    .dividend  (md_operand_1),
    .divisor   (md_operand_2),
    .last      (div_last),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (commit) begin
      hi_r <= md_result[63:32];
      lo_r <= md_result[31:0];
    end else if (hilo_write_en) begin
      hi_r <= hi_in;
      lo_r <= lo_in;
    end
  end

  assign hi_out = commit ? md_result[63:32] : (hilo_write_en ? hi_in : hi_r);
  assign lo_out = commit ? md_result[31:0]  : (hilo_write_en ? lo_in : lo_r);

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: multiply/divide results and latency, MTHI/MTLO
// bypass, commit priority, flush, reset, and the optional accumulate ops.
module tb_hilo_unit;

  localparam int MULC = 2;
  localparam int DIVL = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        hilo_write_en;
  logic [31:0] hi_in, lo_in;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] md_operand_1, md_operand_2;
  logic        flush;
  logic        md_busy, md_done;
  logic [31:0] hi_out, lo_out;

  int n_assert = 0;
  int n_fail   = 0;

  int          lat, busy_n, dones;
  logic [31:0] rhi, rlo;

  hilo_unit #(
    .MUL_CYCLES (MULC),
    .DIV_CYCLES (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .hilo_write_en (hilo_write_en),
    .hi_in         (hi_in),
    .lo_in         (lo_in),
    .md_start      (md_start),
    .md_op         (md_op),
    .md_operand_1  (md_operand_1),
    .md_operand_2  (md_operand_2),
    .flush         (flush),
    .md_busy       (md_busy),
    .md_done       (md_done),
    .hi_out        (hi_out),
    .lo_out        (lo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation, then scramble the operand inputs and wait for md_done.
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int l, output int bn, output logic [31:0] h, output logic [31:0] lo);
    step();
    md_start = 1'b1; md_op = op; md_operand_1 = a; md_operand_2 = b;
    @(negedge clk);
    chk("busy_in_start_cycle", {31'b0, md_busy}, 32'd0);
    step();
    md_start = 1'b0; md_operand_1 = $urandom; md_operand_2 = $urandom;
    l = 0; bn = 0; h = '0; lo = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (md_busy) bn++;
      if (md_done) begin
        l = i; h = hi_out; lo = lo_out;
        break;
      end
      step();
    end
  endtask

  initial begin
    rst = 1'b1; hilo_write_en = 1'b0; hi_in = '0; lo_in = '0;
    md_start = 1'b0; md_op = '0; md_operand_1 = '0; md_operand_2 = '0; flush = 1'b0;
    #2;
    chk("reset_busy", {31'b0, md_busy}, 32'd0);
    chk("reset_done", {31'b0, md_done}, 32'd0);
    chk("reset_hi", hi_out, 32'd0);
    chk("reset_lo", lo_out, 32'd0);
    step(); step();
    rst = 1'b0;

    run_md(3'd0, 32'hFFFF_FFFD, 32'h0000_0005, lat, busy_n, rhi, rlo);
    chk("mult_latency", lat, MULC);
    chk("mult_busy_cycles", busy_n, MULC);
    chk("mult_hi", rhi, 32'hFFFF_FFFF);
    chk("mult_lo", rlo, 32'hFFFF_FFF1);
    step(); @(negedge clk);
    chk("mult_idle_after", {31'b0, md_busy}, 32'd0);
    chk("mult_hi_stored", hi_out, 32'hFFFF_FFFF);

    run_md(3'd1, 32'hFFFF_FFFD, 32'h0000_0005, lat, busy_n, rhi, rlo);
    chk("multu_hi", rhi, 32'h0000_0004);
    chk("multu_lo", rlo, 32'hFFFF_FFF1);

    run_md(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, lat, busy_n, rhi, rlo);
    chk("div_latency", lat, DIVL);
    chk("div_busy_cycles", busy_n, DIVL);
    chk("div_lo", rlo, 32'hFFFF_FFFD);
    chk("div_hi", rhi, 32'hFFFF_FFFF);

    run_md(3'd2, 32'h0000_0007, 32'hFFFF_FFFE, lat, busy_n, rhi, rlo);
    chk("div_negdivisor_lo", rlo, 32'hFFFF_FFFD);
    chk("div_negdivisor_hi", rhi, 32'h0000_0001);

    run_md(3'd3, 32'd100, 32'd7, lat, busy_n, rhi, rlo);
    chk("divu_latency", lat, DIVL);
    chk("divu_lo", rlo, 32'd14);
    chk("divu_hi", rhi, 32'd2);
    step(); @(negedge clk);
    chk("divu_lo_stored", lo_out, 32'd14);

    run_md(3'd3, 32'd7, 32'd0, lat, busy_n, rhi, rlo);
    chk("divzero_lo", rlo, 32'hFFFF_FFFF);
    chk("divzero_hi", rhi, 32'd7);

    run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, busy_n, rhi, rlo);
    chk("divovf_lo", rlo, 32'h8000_0000);
    chk("divovf_hi", rhi, 32'h0000_0000);

    // MTHI/MTLO write: visible the same cycle, then held
    step();
    hilo_write_en = 1'b1; hi_in = 32'h1234_5678; lo_in = 32'h9ABC_DEF0;
    @(negedge clk);
    chk("write_bypass_hi", hi_out, 32'h1234_5678);
    chk("write_bypass_lo", lo_out, 32'h9ABC_DEF0);
    step();
    hilo_write_en = 1'b0; hi_in = 32'hDEAD_BEEF; lo_in = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("write_persist_hi", hi_out, 32'h1234_5678);
    chk("write_persist_lo", lo_out, 32'h9ABC_DEF0);

    // Write colliding with the DONE cycle of MULT 3*4
    step();
    md_start = 1'b1; md_op = 3'd0; md_operand_1 = 32'd3; md_operand_2 = 32'd4;
    step();
    md_start = 1'b0;
    step();
    hilo_write_en = 1'b1; hi_in = 32'hAAAA_AAAA; lo_in = 32'h5555_5555;
    @(negedge clk);
    chk("collide_done", {31'b0, md_done}, 32'd1);
    chk("collide_bypass_lo", lo_out, 32'd12);
    step();
    hilo_write_en = 1'b0;
    @(negedge clk);
    chk("collide_stored_hi", hi_out, 32'd0);
    chk("collide_stored_lo", lo_out, 32'd12);

    // Flush a divide at t+10; a start at t+1 while busy is ignored
    step();
    md_start = 1'b1; md_op = 3'd3; md_operand_1 = 32'd100; md_operand_2 = 32'd7;
    step();
    md_op = 3'd0; md_operand_1 = 32'd9; md_operand_2 = 32'd9;
    step();
    md_start = 1'b0;
    for (int i = 3; i <= 10; i++) step();
    @(negedge clk);
    chk("flush_busy_before", {31'b0, md_busy}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy_after", {31'b0, md_busy}, 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      step(); @(negedge clk);
      if (md_done) dones++;
    end
    chk("flush_no_done", dones, 0);
    chk("flush_hi_kept", hi_out, 32'd0);
    chk("flush_lo_kept", lo_out, 32'd12);

    // flush and start together: nothing launches
    step();
    md_start = 1'b1; md_op = 3'd0; md_operand_1 = 32'd5; md_operand_2 = 32'd5; flush = 1'b1;
    step();
    md_start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flushstart_busy", {31'b0, md_busy}, 32'd0);
    step(); step(); @(negedge clk);
    chk("flushstart_lo_kept", lo_out, 32'd12);

`ifdef HILO_MADD_EN
    step();
    hilo_write_en = 1'b1; hi_in = 32'd0; lo_in = 32'd10;
    step();
    hilo_write_en = 1'b0;
    run_md(3'd4, 32'd3, 32'd4, lat, busy_n, rhi, rlo);
    chk("madd_latency", lat, MULC);
    chk("madd_hi", rhi, 32'd0);
    chk("madd_lo", rlo, 32'd22);
    run_md(3'd7, 32'd1, 32'd23, lat, busy_n, rhi, rlo);
    chk("msubu_hi", rhi, 32'hFFFF_FFFF);
    chk("msubu_lo", rlo, 32'hFFFF_FFFF);
`else
    step();
    md_start = 1'b1; md_op = 3'd5; md_operand_1 = 32'd3; md_operand_2 = 32'd4;
    step();
    md_start = 1'b0;
    @(negedge clk);
    chk("unused_op_busy", {31'b0, md_busy}, 32'd0);
    step(); step(); @(negedge clk);
    chk("unused_op_lo_kept", lo_out, 32'd12);
`endif

    // Asynchronous reset in the middle of a multiply
    step();
    md_start = 1'b1; md_op = 3'd0; md_operand_1 = 32'd6; md_operand_2 = 32'd7;
    step();
    md_start = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", {31'b0, md_busy}, 32'd0);
    chk("rst_mid_done", {31'b0, md_done}, 32'd0);
    chk("rst_mid_hi", hi_out, 32'd0);
    chk("rst_mid_lo", lo_out, 32'd0);
    step();
    rst = 1'b0;
    step(); step(); @(negedge clk);
    chk("rst_mid_lo_after", lo_out, 32'd0);

    run_md(3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, lat, busy_n, rhi, rlo);
    chk("mult_after_rst_latency", lat, MULC);
    chk("mult_after_rst_hi", rhi, 32'h3FFF_FFFF);
    chk("mult_after_rst_lo", rlo, 32'h0000_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
